// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   localparam int unsigned P_CPU = 0;
   localparam int unsigned P_DBG = 1;

   localparam int unsigned MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the port that did not win last gets ties.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic [1:0] o_gnt
);

   // i_last_gnt = 1 means port 1 won last time, so port 0 takes a tie.
   assign o_gnt[P_CPU] = i_req[P_CPU] & (~i_req[P_DBG] | i_last_gnt);
   assign o_gnt[P_DBG] = i_req[P_DBG] & (~i_req[P_CPU] | ~i_last_gnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the CPU port and the debug/loader port,
// with round-robin ties and a bounded lock for read-modify-write sequences.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned MAX_HOLD   = MAX_HOLD_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_we0,
   input  logic                  i_we1,
   input  logic                  i_lock0,
   input  logic                  i_lock1,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_wdata0,
   input  logic [DATA_WIDTH-1:0] i_wdata1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_rvalid0,
   output logic                  o_rvalid1,
   output logic [DATA_WIDTH-1:0] o_rdata0,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic                  o_mem_we,
   input  logic [DATA_WIDTH-1:0] i_mem_data
);

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

   arb_state_e            r_state, w_state_d;
   logic                  r_last_gnt, w_last_gnt_d;
   logic [3:0]            r_hold_cnt, w_hold_cnt_d;
   logic [1:0]            w_req, w_rr_gnt, w_gnt_raw, w_gnt;
   logic                  r_rvalid0, r_rvalid1;
   logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
   logic                  w_rd0, w_rd1;

   assign w_req = {i_req1, i_req0};

   rr_arb2 u_rr_arb2 (
      .i_req      (w_req),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_rr_gnt)
   );

   always_comb begin
      w_gnt_raw    = 2'b00;
      w_state_d    = r_state;
      w_last_gnt_d = r_last_gnt;
      w_hold_cnt_d = r_hold_cnt;
      unique case (r_state)
         ARB: begin
            w_gnt_raw = w_rr_gnt;
            if (w_rr_gnt[P_CPU]) begin
               w_last_gnt_d = 1'b0;
               // A one-cycle bound is already met by the grant cycle itself.
               if (i_lock0 && (MAX_HOLD > 1)) begin
                  w_state_d    = LOCK0;
                  w_hold_cnt_d = 4'd1;
               end
            end else if (w_rr_gnt[P_DBG]) begin
               w_last_gnt_d = 1'b1;
               if (i_lock1 && (MAX_HOLD > 1)) begin
                  w_state_d    = LOCK1;
                  w_hold_cnt_d = 4'd1;
               end
            end
         end
         LOCK0: begin
            w_gnt_raw[P_CPU] = i_req0;
            w_hold_cnt_d     = r_hold_cnt + 4'd1;
            if (!i_lock0 || (w_hold_cnt_d >= HOLD_LIMIT)) begin
               w_state_d    = ARB;
               w_last_gnt_d = 1'b0;
               w_hold_cnt_d = 4'd0;
            end
         end
         LOCK1: begin
            w_gnt_raw[P_DBG] = i_req1;
            w_hold_cnt_d     = r_hold_cnt + 4'd1;
            if (!i_lock1 || (w_hold_cnt_d >= HOLD_LIMIT)) begin
               w_state_d    = ARB;
               w_last_gnt_d = 1'b1;
               w_hold_cnt_d = 4'd0;
            end
         end
         default: w_state_d = ARB;
      endcase
   end

   // Grants are masked during reset so no memory write can land on an edge in reset.
   assign w_gnt  = w_gnt_raw & {2{i_rst_n}};
   assign o_gnt0 = w_gnt[P_CPU];
   assign o_gnt1 = w_gnt[P_DBG];

   always_comb begin
      o_mem_addr = '0;
      o_mem_data = '0;
      o_mem_we   = 1'b0;
      if (w_gnt[P_CPU]) begin
         o_mem_addr = i_addr0;
         o_mem_data = i_wdata0;
         o_mem_we   = i_we0;
      end else if (w_gnt[P_DBG]) begin
         o_mem_addr = i_addr1;
         o_mem_data = i_wdata1;
         o_mem_we   = i_we1;
      end
   end

   assign w_rd0 = w_gnt[P_CPU] & ~i_we0;
   assign w_rd1 = w_gnt[P_DBG] & ~i_we1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ARB;
         r_last_gnt <= 1'b1;
         r_hold_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_d;
         r_last_gnt <= w_last_gnt_d;
         r_hold_cnt <= w_hold_cnt_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_rd0;
         r_rvalid1 <= w_rd1;
         if (w_rd0) r_rdata0 <= i_mem_data;
         if (w_rd1) r_rdata1 <= i_mem_data;
      end
   end

   assign o_rvalid0 = r_rvalid0;
   assign o_rvalid1 = r_rvalid1;
   assign o_rdata0  = r_rdata0;
   assign o_rdata1  = r_rdata1;

endmodule
